// File: rtl/display_encoder_if.sv
// Bundle of the display_encoder request, status and UART-TX handshake signals.
// master = encoder side, slave = the environment (requester plus UART transmitter).
interface display_encoder_if;
    logic        start;
    logic [31:0] seg_data;
    logic [7:0]  data_en;
    logic        tx_busy;
    logic        tx_data_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    modport master (
        input  start, seg_data, data_en, tx_busy,
        output tx_data_valid, tx_data, busy, done
    );

    modport slave (
        output start, seg_data, data_en, tx_busy,
        input  tx_data_valid, tx_data, busy, done
    );
endinterface

// File: rtl/display_encoder.sv
// Streams a snapshot of the 8-digit display to a UART transmitter, most significant enabled unit first.
// Define DISPLAY_ENCODER_HEX_EN for raw hex bytes (4 two-digit units); default is ASCII, one digit per byte.
module display_encoder (
    input  logic               clk,
    input  logic               rst_n,
    display_encoder_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WAIT_ACK,
        WAIT_DONE,
        FIN
    } state_t;

    state_t      state, next_state;
    logic [2:0]  idx, next_idx;
    logic [31:0] snap_data, next_snap_data;
    logic [7:0]  snap_en, next_snap_en;
    logic [7:0]  next_tx_data;
    logic        next_tx_data_valid;
    logic        next_busy;
    logic        next_done;

    logic        unit_en;
    logic [7:0]  unit_byte;

`ifdef DISPLAY_ENCODER_HEX_EN
    localparam logic [2:0] FIRST_IDX = 3'd3;
    // Unit j carries digits 2j+1:2j; the upper digit's enable gates the whole byte.
    assign unit_en   = snap_en[{idx[1:0], 1'b1}];
    assign unit_byte = snap_data[{idx[1:0], 3'b000} +: 8];
`else
    localparam logic [2:0] FIRST_IDX = 3'd7;
    assign unit_en   = snap_en[idx];
    assign unit_byte = {4'h0, snap_data[{idx, 2'b00} +: 4]} + 8'd48;
`endif

    // NOTE: every next_* gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_state         = state;
        next_idx           = idx;
        next_snap_data     = snap_data;
        next_snap_en       = snap_en;
        next_tx_data       = bus.tx_data;
        next_tx_data_valid = 1'b0;
        next_busy          = bus.busy;
        next_done          = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    next_snap_data = bus.seg_data;
                    next_snap_en   = bus.data_en;
                    next_idx       = FIRST_IDX;
                    next_busy      = 1'b1;
                    next_state     = SCAN;
                end
            end

            SCAN: begin
                if (!unit_en) begin
                    if (idx == 3'd0) begin
                        next_state = FIN;
                    end else begin
                        next_idx = idx - 3'd1;
                    end
                end else if (!bus.tx_busy) begin
                    next_tx_data       = unit_byte;
                    next_tx_data_valid = 1'b1;
                    next_state         = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    next_state = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx == 3'd0) begin
                        next_state = FIN;
                    end else begin
                        next_idx   = idx - 3'd1;
                        next_state = SCAN;
                    end
                end
            end

            FIN: begin
                next_done  = 1'b1;
                next_busy  = 1'b0;
                next_state = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            idx               <= 3'd7;
            snap_data         <= '0;
            snap_en           <= '0;
            bus.tx_data       <= 8'h00;
            bus.tx_data_valid <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            state             <= next_state;
            idx               <= next_idx;
            snap_data         <= next_snap_data;
            snap_en           <= next_snap_en;
            bus.tx_data       <= next_tx_data;
            bus.tx_data_valid <= next_tx_data_valid;
            bus.busy          <= next_busy;
            bus.done          <= next_done;
        end
    end

endmodule

// File: tb/tb_display_encoder.sv
// Scoreboard bench for display_encoder: a digit-list reference model fills the expected queue,
// a negedge monitor with a UART busy model pops and compares every strobe and done pulse.
module tb_display_encoder;

`ifdef DISPLAY_ENCODER_HEX_EN
    localparam int N_UNITS = 4;
`else
    localparam int N_UNITS = 8;
`endif

    logic clk;
    logic rst_n;

    display_encoder_if bus ();

    display_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_q[$];
    int         pending_seq = 0;
    int         strobe_cnt  = 0;
    int         done_seen   = 0;
    int         cyc         = 0;
    int         start_cyc   = 0;
    int         done_cyc    = 0;
    int         last_strobe_cyc = 0;
    logic       busy_at_edge = 1'b0;
    logic       prev_valid   = 1'b0;
    logic       prev_done    = 1'b0;
    int         uart_len = 10;
    int         uart_cnt = 0;
    logic       uart_busy = 1'b0;
    logic       hold_busy = 1'b0;

    assign bus.tx_busy = uart_busy | hold_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list the enabled units from the top down and format each one.
    function automatic void push_expected(input logic [31:0] seg, input logic [7:0] en);
`ifdef DISPLAY_ENCODER_HEX_EN
        for (int j = 3; j >= 0; j--)
            if (en[2*j+1]) exp_q.push_back(8'((seg >> (8*j)) & 32'hFF));
`else
        for (int d = 7; d >= 0; d--)
            if (en[d]) exp_q.push_back(8'(((seg >> (4*d)) & 32'hF) + 32'd48));
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        busy_at_edge = bus.tx_busy;
    end

    // Monitor first, then the UART busy model, so ordering inside the negedge is fixed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_data_valid) begin
                strobe_cnt++;
                last_strobe_cyc = cyc;
                check("strobe_while_tx_busy", {31'd0, busy_at_edge}, 32'd0);
                check("strobe_width", {31'd0, prev_valid}, 32'd0);
                check("busy_during_byte", {31'd0, bus.busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (bus.done) begin
                done_seen++;
                done_cyc = cyc;
                check("done_width", {31'd0, prev_done}, 32'd0);
                check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
                check("bytes_left_at_done", exp_q.size(), 32'd0);
                check("done_expected", {31'd0, pending_seq > 0}, 32'd1);
                if (pending_seq > 0) pending_seq--;
            end else if (pending_seq > 0 && cyc > start_cyc) begin
                check("busy_throughout", {31'd0, bus.busy}, 32'd1);
            end
            prev_valid = bus.tx_data_valid;
            prev_done  = bus.done;
        end
        if (!rst_n)                 uart_cnt = 0;
        else if (bus.tx_data_valid) uart_cnt = uart_len;
        else if (uart_cnt > 0)      uart_cnt--;
        uart_busy = (uart_cnt > 0);
    end

    task automatic issue(input logic [31:0] seg, input logic [7:0] en);
        @(negedge clk);
        bus.seg_data = seg;
        bus.data_en  = en;
        bus.start    = 1'b1;
        push_expected(seg, en);
        pending_seq++;
        start_cyc = cyc + 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.seg_data = $urandom;
        bus.data_en  = 8'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen < target) check("done_timeout", done_seen, target);
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobe_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (strobe_cnt < target) check("strobe_timeout", strobe_cnt, target);
    endtask

    initial begin
        int tgt;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.seg_data = 32'h1234_5678;
        bus.data_en  = 8'hFF;

        // Reset held with start asserted: everything stays at zero.
        repeat (3) @(negedge clk);
        check("reset_outputs", {21'd0, bus.tx_data_valid, bus.tx_data, bus.busy, bus.done}, 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", {22'd0, bus.busy, bus.tx_data_valid, strobe_cnt[7:0]}, 32'd0);

        // Full display, 10-cycle UART, first byte one edge after the start edge.
        uart_len = 10;
        tgt = done_seen + 1;
        issue(32'h1234_5678, 8'hFF);
        wait_strobes(strobe_cnt + 1);
        check("first_strobe_latency", last_strobe_cyc - start_cyc, 32'd1);
        wait_done(tgt);

        // Sparse enables.
        tgt = done_seen + 1;
        issue(32'h0000_0395, 8'h07);
        wait_done(tgt);

        // No enables: pure scan, done N_UNITS+1 edges after the start edge.
        tgt = done_seen + 1;
        issue(32'hDEAD_BEEF, 8'h00);
        wait_done(tgt);
        check("empty_done_latency", done_cyc - start_cyc, N_UNITS + 1);

        // UART held busy for 50 cycles, then start re-pulsed mid-sequence.
        tgt = done_seen + 1;
        hold_busy = 1'b1;
        issue(32'h8765_4321, 8'hFF);
        repeat (48) @(negedge clk);
        hold_busy = 1'b0;
        wait_strobes(strobe_cnt + 2);
        bus.seg_data = 32'hFFFF_FFFF;
        bus.data_en  = 8'hFF;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(tgt);

        // Reset pulsed a few cycles after the third byte, then a clean resend.
        issue(32'hCAFE_F00D, 8'hFF);
        wait_strobes(strobe_cnt + 3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midseq_reset_outputs", {21'd0, bus.tx_data_valid, bus.tx_data, bus.busy, bus.done}, 32'd0);
        exp_q.delete();
        pending_seq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_midseq_reset", {31'd0, bus.busy}, 32'd0);
        tgt = done_seen + 1;
        issue(32'h1234_5678, 8'hFF);
        wait_done(tgt);

`ifdef DISPLAY_ENCODER_HEX_EN
        tgt = done_seen + 1;
        issue(32'hA1B2_C3D4, 8'h0F);
        wait_done(tgt);
`endif

        // Randomized sequences with varying UART byte times.
        for (int i = 0; i < 12; i++) begin
            uart_len = $urandom_range(1, 12);
            tgt = done_seen + 1;
            issue($urandom, 8'($urandom_range(0, 255)));
            wait_done(tgt);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
